// File: rtl/mem_stage.sv
// Memory-access stage downstream of execute: ALU results pass through, LW/SW run a data-memory req/ack transaction.
// Latency: 1 cycle for non-memory ops and misaligned rejects, 2+ cycles for LW/SW (1 accept cycle + N REQ cycles).
// Backpressure: stall holds upstream from the accept cycle until the cycle the transaction ends (ack or timeout).
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid, op, regcData,   execute-stage result bundle
//   regcAddr, regcWrite,
//   memAddr, memData
//   stall                     combinational hold for upstream stages
//   mem_req, mem_we,          data-memory request port (req/ack handshake)
//   mem_addr, mem_wdata,
//   mem_rdata, mem_ack
//   wb_valid, wb_data,        write-back bundle (wb_valid is a 1-cycle pulse)
//   wb_addr, wb_we
//   err                       1-cycle pulse on misaligned access or memory timeout

module mem_stage #(
  parameter logic [5:0]  OP_LW   = 6'b100011,
  parameter logic [5:0]  OP_SW   = 6'b101011,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [31:0] regcData,
  input  logic [4:0]  regcAddr,
  input  logic        regcWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_we,
  output logic        err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // TIMEOUT == 0 disables the abort; the counter then simply free-runs while in REQ.
  localparam bit          HAS_TO  = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = HAS_TO ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_cnt;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [4:0]  r_rd_addr;
  logic        r_rd_we;
  logic        r_is_sw;

  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;
  logic        r_wb_we;
  logic        r_err;

  logic        w_is_mem;
  logic        w_misalign;
  logic        w_accept;
  logic        w_timeout;

  assign w_is_mem   = (op == OP_LW) || (op == OP_SW);
  assign w_misalign = (memAddr[1:0] != 2'b00);
  assign w_accept   = (r_state == S_IDLE) && in_valid && w_is_mem && !w_misalign;
  // Only meaningful in REQ without ack; an ack in the same cycle wins.
  assign w_timeout  = HAS_TO && (r_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Hold upstream already in the accept cycle so the load/store bundle
        // is not overwritten before the request completes.
        stall = w_accept;
      end
      S_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = r_is_sw;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latches, timeout counter and write-back bundle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rd_addr   <= 5'd0;
      r_rd_we     <= 1'b0;
      r_is_sw     <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_addr   <= 5'd0;
      r_wb_we     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= regcData;
              r_wb_addr  <= regcAddr;
              r_wb_we    <= regcWrite;
            end else if (w_misalign) begin
              // Rejected without touching memory; data/addr keep old values.
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_mem_addr  <= memAddr;
              r_mem_wdata <= memData;
              r_rd_addr   <= regcAddr;
              r_rd_we     <= regcWrite;
              r_is_sw     <= (op == OP_SW);
              r_cnt       <= 32'd0;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_wb_valid <= 1'b1;
            r_cnt      <= 32'd0;
            if (r_is_sw) begin
              r_wb_we <= 1'b0;
            end else begin
              r_wb_data <= mem_rdata;
              r_wb_addr <= r_rd_addr;
              r_wb_we   <= r_rd_we;
            end
          end else if (w_timeout) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b0;
            r_err      <= 1'b1;
            r_cnt      <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign wb_addr   = r_wb_addr;
  assign wb_we     = r_wb_we;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, LW/SW transactions, misalignment,
// timeout (TIMEOUT=4), ack racing the timeout, reset mid-transaction.
// Write-back results are checked against a scoreboard queue filled when stimulus is driven.

module tb_mem_stage;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [5:0]  op;
  logic [31:0] regcData;
  logic [4:0]  regcAddr;
  logic        regcWrite;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        err;
    logic        chk_payload;
  } wb_exp_t;

  wb_exp_t sb[$];

  mem_stage #(
    .OP_LW  (OP_LW),
    .OP_SW  (OP_SW),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .op       (op),
    .regcData (regcData),
    .regcAddr (regcAddr),
    .regcWrite(regcWrite),
    .memAddr  (memAddr),
    .memData  (memData),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] a, input logic we,
                      input logic e, input logic cp);
    wb_exp_t x;
    x.data = d; x.addr = a; x.we = we; x.err = e; x.chk_payload = cp;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every write-back pulse must match the oldest expectation.
  wb_exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL wb_unexpected observed=wb_valid=1 expected=no write-back");
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_wb_we", 32'(wb_we), 32'(mon_e.we));
          chk("sb_err", 32'(err), 32'(mon_e.err));
          if (mon_e.chk_payload) begin
            chk("sb_wb_data", wb_data, mon_e.data);
            chk("sb_wb_addr", 32'(wb_addr), 32'(mon_e.addr));
          end
        end
      end else if (err) begin
        chk("err_without_wb", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 6'd0; regcData = 32'd0; regcAddr = 5'd0;
    regcWrite = 1'b0; memAddr = 32'd0; memData = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    next_cycle();
    next_cycle();

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    next_cycle();
    rst = 1'b0;

    // ALU pass, then back-to-back ALU op
    in_valid = 1'b1; op = OP_OR; regcData = 32'h1234; regcAddr = 5'd5; regcWrite = 1'b1;
    push(32'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    op = OP_ADD; regcData = 32'h5678; regcAddr = 5'd9; regcWrite = 1'b0;
    push(32'h5678, 5'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_addr", 32'(wb_addr), 32'd5);
    chk("alu_wb_we", 32'(wb_we), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b_wb_data", wb_data, 32'h5678);
    next_cycle();

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    mem_ack = 1'b0;

    // LW with ack on the 3rd REQ cycle; an ALU op offered during REQ is ignored
    in_valid = 1'b1; op = OP_LW; memAddr = 32'h40; regcAddr = 5'd7; regcWrite = 1'b1;
    push(32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("lw_accept_stall", 32'(stall), 32'd1);
    chk("lw_accept_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    op = OP_OR; regcData = 32'h99;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      chk("lw_req_mem_req", 32'(mem_req), 32'd1);
      chk("lw_req_stall", 32'(stall), 32'd1);
      chk("lw_req_mem_addr", mem_addr, 32'h40);
      chk("lw_req_mem_we", 32'(mem_we), 32'd0);
      next_cycle();
    end
    in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("lw_done_mem_req", 32'(mem_req), 32'd0);
    chk("lw_done_stall", 32'(stall), 32'd0);
    chk("lw_done_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw_done_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_done_wb_we", 32'(wb_we), 32'd1);
    next_cycle();

    // SW with immediate ack
    in_valid = 1'b1; op = OP_SW; memAddr = 32'h8; memData = 32'hA5A5A5A5; regcAddr = 5'd3;
    regcWrite = 1'b0;
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sw_accept_stall", 32'(stall), 32'd1);
    next_cycle();
    in_valid = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("sw_mem_req", 32'(mem_req), 32'd1);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sw_mem_addr", mem_addr, 32'h8);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("sw_done_mem_req", 32'(mem_req), 32'd0);
    chk("sw_done_wb_valid", 32'(wb_valid), 32'd1);
    chk("sw_done_wb_we", 32'(wb_we), 32'd0);
    chk("sw_done_err", 32'(err), 32'd0);
    next_cycle();

    // Misaligned LW
    in_valid = 1'b1; op = OP_LW; memAddr = 32'h6; regcAddr = 5'd4; regcWrite = 1'b1;
    push(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mis_next_mem_req", 32'(mem_req), 32'd0);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_wb_we", 32'(wb_we), 32'd0);
    next_cycle();

    // Timeout: no ack, TIMEOUT=4 -> 4 REQ cycles then error
    in_valid = 1'b1; op = OP_LW; memAddr = 32'h10; regcAddr = 5'd6; regcWrite = 1'b1;
    push(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("to_accept_stall", 32'(stall), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_mem_req", 32'(mem_req), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("to_done_mem_req", 32'(mem_req), 32'd0);
    chk("to_done_stall", 32'(stall), 32'd0);
    chk("to_done_err", 32'(err), 32'd1);
    chk("to_done_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_done_wb_we", 32'(wb_we), 32'd0);
    next_cycle();

    // Ack arriving on the timeout cycle wins over the timeout
    in_valid = 1'b1; op = OP_LW; memAddr = 32'h20; regcAddr = 5'd12; regcWrite = 1'b1;
    push(32'hCAFEF00D, 5'd12, 1'b1, 1'b0, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("race_mem_req", 32'(mem_req), 32'd1);
      next_cycle();
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("race_err", 32'(err), 32'd0);
    chk("race_wb_valid", 32'(wb_valid), 32'd1);
    chk("race_wb_data", wb_data, 32'hCAFEF00D);
    next_cycle();

    // Reset on the 2nd REQ cycle of a LW abandons it
    in_valid = 1'b1; op = OP_LW; memAddr = 32'h44; regcAddr = 5'd8; regcWrite = 1'b1;
    @(negedge clk);
    chk("rstlw_accept_stall", 32'(stall), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstlw_req1_mem_req", 32'(mem_req), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rstlw_req2_mem_req", 32'(mem_req), 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstlw_mem_req", 32'(mem_req), 32'd0);
    chk("rstlw_stall", 32'(stall), 32'd0);
    chk("rstlw_wb_valid", 32'(wb_valid), 32'd0);
    next_cycle();

    // ALU op after reset behaves normally
    in_valid = 1'b1; op = OP_OR; regcData = 32'h1234; regcAddr = 5'd5; regcWrite = 1'b1;
    push(32'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_alu_stall", 32'(stall), 32'd0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
    chk("post_rst_wb_data", wb_data, 32'h1234);
    chk("post_rst_wb_addr", 32'(wb_addr), 32'd5);
    chk("post_rst_wb_we", 32'(wb_we), 32'd1);
    next_cycle();
    next_cycle();
    next_cycle();

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
